// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared main-memory request types and arbiter defaults
package mem_req_arbiter_pkg;
  localparam int MEM_ARB_MAX_INFLIGHT = 4;
  localparam int MAIN_MEM_BLOCK_ADDR_W = 26;
  localparam int BLOCK_DATA_W = 64;
  typedef logic [MAIN_MEM_BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_W-1:0] block_data_t;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;
  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_type_t;
endpackage

// File: rtl/mem_req_arbiter_route_fifo.sv
// mem_req_arbiter_route_fifo: in-order source tags of outstanding reads
module mem_req_arbiter_route_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = MEM_ARB_MAX_INFLIGHT
) (
  input  logic        clk,
  input  logic        rst_aH,
  input  logic        push_i,
  input  cache_type_t din_i,
  input  logic        pop_i,
  output cache_type_t head_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] tags_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic push, pop;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  // when full, a same-cycle pop frees the slot the push overwrites
  assign push = push_i && (!full_o || pop_i);
  assign pop = pop_i && !empty_o;
  assign head_o = cache_type_t'(tags_q[rd_ptr_q]);
  always_ff @(posedge clk or posedge rst_aH)
    if (rst_aH) begin
      tags_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tags_q[wr_ptr_q] <= din_i;
        wr_ptr_q <= wrap_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin I/D-cache miss arbiter with in-order response routing
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_INFLIGHT = MEM_ARB_MAX_INFLIGHT
) (
  input  logic                 clk,
  input  logic                 rst_aH,
  input  logic                 icache_req_valid,
  input  main_mem_block_addr_t icache_req_block_addr,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,
  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data,
  output logic                 mem_req_valid,
  output req_type_t            mem_req_type,
  output main_mem_block_addr_t mem_req_block_addr,
  output block_data_t          mem_req_block_data,
  input  logic                 mem_resp_valid,
  input  block_data_t          mem_resp_block_data,
  output logic                 err_spurious_resp
);
  logic full, empty, i_elig, d_elig, i_win, d_win, grant, push, hit;
  cache_type_t head, push_tag, prio_q, prio_d;
  logic mem_req_valid_q, icache_resp_valid_q, dcache_resp_valid_q, err_q;
  req_type_t mem_req_type_q;
  main_mem_block_addr_t mem_req_addr_q;
  block_data_t mem_req_data_q, icache_resp_data_q, dcache_resp_data_q;
  always_comb begin
    i_elig = icache_req_valid && !full && !rst_aH;
    d_elig = dcache_req_valid && (dcache_req_type == WRITE || !full) && !rst_aH;
    i_win = i_elig && (!d_elig || prio_q == ICACHE);
    d_win = d_elig && !i_win;
    grant = i_win || d_win;
    push = i_win || (d_win && dcache_req_type == READ);
    push_tag = i_win ? ICACHE : DCACHE;
    prio_d = i_elig && d_elig ? (i_win ? DCACHE : ICACHE) : prio_q;
    hit = mem_resp_valid && !empty;
  end
  mem_req_arbiter_route_fifo #(.DEPTH(MAX_INFLIGHT)) u_route_fifo (
    .clk     (clk),
    .rst_aH  (rst_aH),
    .push_i  (push),
    .din_i   (push_tag),
    .pop_i   (mem_resp_valid),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk or posedge rst_aH)
    if (rst_aH) begin
      prio_q <= ICACHE;
      mem_req_valid_q <= 1'b0;
      mem_req_type_q <= READ;
      mem_req_addr_q <= '0;
      mem_req_data_q <= '0;
      icache_resp_valid_q <= 1'b0;
      dcache_resp_valid_q <= 1'b0;
      icache_resp_data_q <= '0;
      dcache_resp_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      mem_req_valid_q <= grant;
      if (grant) begin
        mem_req_type_q <= i_win ? READ : dcache_req_type;
        mem_req_addr_q <= i_win ? icache_req_block_addr : dcache_req_block_addr;
        mem_req_data_q <= i_win ? '0 : dcache_req_block_data;
      end
      icache_resp_valid_q <= hit && head == ICACHE;
      dcache_resp_valid_q <= hit && head == DCACHE;
      if (hit && head == ICACHE) icache_resp_data_q <= mem_resp_block_data;
      if (hit && head == DCACHE) dcache_resp_data_q <= mem_resp_block_data;
      if (mem_resp_valid && empty) err_q <= 1'b1;
    end
  assign icache_req_ready = i_win;
  assign dcache_req_ready = d_win;
  assign icache_resp_valid = icache_resp_valid_q;
  assign icache_resp_block_data = icache_resp_data_q;
  assign dcache_resp_valid = dcache_resp_valid_q;
  assign dcache_resp_block_data = dcache_resp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_type = mem_req_type_q;
  assign mem_req_block_addr = mem_req_addr_q;
  assign mem_req_block_data = mem_req_data_q;
  assign err_spurious_resp = err_q;
endmodule
